bnn_layer_sequencer: RTL and testbench
======================================

// Module: bnn_layer_sequencer
// PURPOSE
//  Time-multiplexed evaluator for one binary fully-connected layer (e.g. 75 in -> 50 out).
//  Replaces the flat per-neuron combinational array with a single shared XNOR-popcount-threshold
//  unit, fed by an external weight/threshold memory. Accepts one input vector, evaluates neuron
//  k = 0..N_OUT-1 at one neuron per cycle, and presents the N_OUT-bit result on a valid/ready port.
//  Two instances can be chained to form the complete two-layer network.
// PARAMETERS
//  N_IN   75                    input vector width (bits per neuron weight row)
//  N_OUT  50                    neurons in this layer (output vector width)
//  CW     $clog2(N_IN+1)        popcount/threshold width
//  AW     $clog2(N_OUT)         weight memory address width
// PORTS
//  clk       in   1      clock, all state updates on rising edge
//  rst       in   1      asynchronous reset, active-high
//  in_valid  in   1      input vector valid
//  in_ready  out  1      sequencer can accept a vector (high only in IDLE)
//  in_data   in   N_IN   input activations (1 = +1, 0 = -1)
//  w_rd_en   out  1      weight memory read strobe
//  w_addr    out  AW     neuron index being fetched
//  w_data    in   N_IN   weight row; returned exactly 1 cycle after w_rd_en
//  w_thr     in   CW     neuron threshold; returned alongside w_data
//  out_valid out  1      result vector valid
//  out_ready in   1      downstream accepts result
//  out_data  out  N_OUT  result bits, out_data[k] = neuron k
//  busy      out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_data=0, w_rd_en=0,
//   w_addr=0, busy=0, internal counters and pipeline valid = 0. No partial result survives.
//  States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready (cycle T0) latch in_data into x_reg, clear out_data,
//   fetch index k=0, go RUN. in_valid while not IDLE is ignored (in_ready=0).
//  RUN: each cycle w_rd_en=1, w_addr=k, k++. When k==N_OUT-1 is issued, go DRAIN.
//   Reads therefore occur at T1..T(N_OUT); w_addr never exceeds N_OUT-1.
//  Evaluate stage (registered valid tracking w_rd_en by 1 cycle): for returned index j,
//   pc = popcount(~(x_reg ^ w_data)) (CW bits, range 0..N_IN); out_data[j] <= (pc >= w_thr).
//   Compare is unsigned; w_thr=0 -> bit 1; w_thr>N_IN -> bit 0. Other out_data bits unchanged.
//  DRAIN: w_rd_en=0; evaluates last neuron (T(N_OUT+1)); go DONE.
//  DONE: out_valid=1 from T(N_OUT+2); out_data stable and w_rd_en=0 while out_ready=0.
//   On out_valid&out_ready go IDLE; in_ready rises the following cycle (one-cycle bubble,
//   no same-cycle accept of a new vector).
//  Latency: accept at T0 -> out_valid at T0+N_OUT+2 (52 cycles at defaults); throughput one
//   vector per N_OUT+3 cycles with out_ready held high.
//  Reset mid-operation: immediate abort as above; memory reads in flight are discarded.
//  N_OUT==1: RUN lasts one cycle, then DRAIN; no special-casing beyond counter compare.
// TESTING
//  1 in_data=all 1, every row all 1, thr=75 -> out_data=all 1 (50 bits), out_valid exactly
//    52 cycles after accept; w_addr sequence 0..49, one per cycle, no gaps.
//  2 in_data=all 1, rows all 0: thr=1 -> out_data=0; repeat with thr=0 -> out_data=all 1;
//    thr=76 with matching rows -> out_data=0.
//  3 Row k = in_data for even k, ~in_data for odd k, thr=38 -> out_data even bits 1, odd 0
//    (50'h1_5555_5555_5555).
//  4 Threshold edge: rows giving exactly 37 and 38 matches with thr=38 -> bits 0 and 1.
//  5 Hold out_ready=0 for 10 cycles in DONE -> out_valid, out_data stable, in_ready=0,
//    w_rd_en=0; assert out_ready -> IDLE next cycle, in_ready=1 the cycle after accept.
//  6 Assert rst while w_addr=20 -> out_valid/out_data/w_rd_en/busy clear in the same
//    cycle; after release a new vector yields correct result starting from w_addr=0.

Source files
------------

// File: rtl/bnn_layer_sequencer.sv
// Time-multiplexed evaluator for one binary fully-connected layer.
// A single XNOR-popcount-threshold unit walks neurons 0..N_OUT-1, one per
// cycle, using weight rows and thresholds from an external 1-cycle-latency
// memory. The assembled N_OUT-bit result is offered on a valid/ready port.
module bnn_layer_sequencer #(
    parameter int unsigned N_IN  = 75,
    parameter int unsigned N_OUT = 50,
    parameter int unsigned CW    = $clog2(N_IN + 1),
    parameter int unsigned AW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [N_IN-1:0]  in_data_i,
    output logic             w_rd_en_o,
    output logic [AW-1:0]    w_addr_o,
    input  logic [N_IN-1:0]  w_data_i,
    input  logic [CW-1:0]    w_thr_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [N_OUT-1:0] out_data_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [AW-1:0] LastIdx = AW'(N_OUT - 1);

    state_e             state_q;
    logic [N_IN-1:0]    x_q;
    logic [AW-1:0]      w_addr_q;
    logic               w_rd_en_q;
    logic               ev_valid_q;
    logic [AW-1:0]      ev_idx_q;
    logic [N_OUT-1:0]   out_data_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               busy_q;

    logic [N_IN-1:0]    match;
    logic [CW-1:0]      pc;
    logic               hit;

    function automatic logic [CW-1:0] popcount(input logic [N_IN-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N_IN; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Shared neuron unit: agreement count of activations vs. the returned row.
    always_comb begin
        match = ~(x_q ^ w_data_i);
        pc    = popcount(match);
        hit   = (pc >= w_thr_i);
    end

    // Sequencer FSM, evaluate stage and all registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            x_q         <= '0;
            w_addr_q    <= '0;
            w_rd_en_q   <= 1'b0;
            ev_valid_q  <= 1'b0;
            ev_idx_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            // Memory answers one cycle after the strobe, so the evaluate
            // stage follows the read port by exactly one cycle.
            ev_valid_q <= w_rd_en_q;
            ev_idx_q   <= w_addr_q;
            if (ev_valid_q) begin
                out_data_q[ev_idx_q] <= hit;
            end

            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        x_q        <= in_data_i;
                        out_data_q <= '0;
                        w_rd_en_q  <= 1'b1;
                        w_addr_q   <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    if (w_addr_q == LastIdx) begin
                        w_rd_en_q <= 1'b0;
                        state_q   <= StDrain;
                    end else begin
                        w_addr_q <= w_addr_q + 1'b1;
                    end
                end
                StDrain: begin
                    // Last neuron is being evaluated this cycle.
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign w_rd_en_o   = w_rd_en_q;
    assign w_addr_o    = w_addr_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed bench for bnn_layer_sequencer: table of vectors plus hand-written
// sequences for output back-pressure and mid-run reset.
module tb_bnn_layer_sequencer;

    localparam int unsigned N_IN  = 75;
    localparam int unsigned N_OUT = 50;
    localparam int unsigned CW    = 7;
    localparam int unsigned AW    = 6;

    localparam logic [N_IN-1:0]  ONES   = {N_IN{1'b1}};
    localparam logic [N_IN-1:0]  ZEROS  = '0;
    localparam logic [N_OUT-1:0] E_ONES = {N_OUT{1'b1}};
    localparam logic [N_OUT-1:0] E_ZERO = '0;
    localparam logic [N_OUT-1:0] E_ALT  = 50'h1_5555_5555_5555;
    localparam logic [N_IN-1:0]  X3     = 75'h5A5_F00F_1234_ABCD_9876;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N_IN-1:0]   in_data;
    logic              w_rd_en;
    logic [AW-1:0]     w_addr;
    logic [N_IN-1:0]   w_data;
    logic [CW-1:0]     w_thr;
    logic              out_valid;
    logic              out_ready;
    logic [N_OUT-1:0]  out_data;
    logic              busy;

    logic [N_IN-1:0]   mem_row [N_OUT];
    logic [CW-1:0]     mem_thr [N_OUT];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string            name;
        logic [N_IN-1:0]  x;
        logic [N_IN-1:0]  row_even;
        logic [N_IN-1:0]  row_odd;
        logic [CW-1:0]    thr_even;
        logic [CW-1:0]    thr_odd;
        logic [N_OUT-1:0] exp;
    } vec_t;

    vec_t vecs [8];

    bnn_layer_sequencer dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .w_rd_en_o   (w_rd_en),
        .w_addr_o    (w_addr),
        .w_data_i    (w_data),
        .w_thr_i     (w_thr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Weight memory model: one-cycle read latency.
    initial begin
        w_data = '0;
        w_thr  = '0;
    end
    always @(posedge clk) begin
        if (w_rd_en) begin
            w_data <= mem_row[w_addr];
            w_thr  <= mem_thr[w_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fill(input logic [N_IN-1:0] re, input logic [N_IN-1:0] ro,
                        input logic [CW-1:0] te, input logic [CW-1:0] to);
        for (int k = 0; k < N_OUT; k++) begin
            mem_row[k] = (k % 2 == 0) ? re : ro;
            mem_thr[k] = (k % 2 == 0) ? te : to;
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic run_vec(input string nm, input logic [N_IN-1:0] x,
                           input logic [N_OUT-1:0] exp, input int hold);
        int   n;
        logic seq_ok;
        logic stable_ok;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
        in_data  = x;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seq_ok = 1'b1;
        for (int i = 0; i < N_OUT; i++) begin
            @(negedge clk);
            if (!(w_rd_en === 1'b1 && w_addr === AW'(i) && busy === 1'b1 &&
                  out_valid === 1'b0 && in_ready === 1'b0))
                seq_ok = 1'b0;
        end
        chk({nm, "_addr_seq"}, 64'(seq_ok), 64'd1);
        n = N_OUT;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, 64'(n), 64'(N_OUT + 2));
        chk({nm, "_data"}, 64'(out_data), 64'(exp));
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && out_data === exp && in_ready === 1'b0 &&
                  w_rd_en === 1'b0 && busy === 1'b1))
                stable_ok = 1'b0;
        end
        if (hold > 0) chk({nm, "_hold_stable"}, 64'(stable_ok), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_idle_after"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
    endtask

    initial begin
        logic [N_IN-1:0] r37;
        logic [N_IN-1:0] r38;
        int              n;

        // Rows with exactly 37 / 38 ones; against x=0 they give 38 / 37 matches.
        r37 = '0;
        r38 = '0;
        for (int i = 0; i < 37; i++) r37[i] = 1'b1;
        for (int i = 0; i < 38; i++) r38[i] = 1'b1;

        vecs[0] = '{"all_match_thr75", ONES, ONES, ONES, 7'd75, 7'd75, E_ONES};
        vecs[1] = '{"no_match_thr1", ONES, ZEROS, ZEROS, 7'd1, 7'd1, E_ZERO};
        vecs[2] = '{"no_match_thr0", ONES, ZEROS, ZEROS, 7'd0, 7'd0, E_ONES};
        vecs[3] = '{"all_match_thr76", ONES, ONES, ONES, 7'd76, 7'd76, E_ZERO};
        vecs[4] = '{"alt_rows_thr38", X3, X3, ~X3, 7'd38, 7'd38, E_ALT};
        vecs[5] = '{"thr_edge_38_37", ZEROS, r37, r38, 7'd38, 7'd38, E_ALT};
        vecs[6] = '{"mixed_thr", ONES, ONES, ONES, 7'd75, 7'd127, E_ALT};
        vecs[7] = '{"inv_alt_rows", ~X3, X3, ~X3, 7'd38, 7'd38, ~E_ALT};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        fill(ZEROS, ZEROS, 7'd0, 7'd0);

        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_data", 64'(out_data), 64'd0);
        chk("reset_rd_en_busy_addr", 64'({w_rd_en, busy, w_addr}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            fill(vecs[v].row_even, vecs[v].row_odd, vecs[v].thr_even, vecs[v].thr_odd);
            run_vec(vecs[v].name, vecs[v].x, vecs[v].exp, 0);
        end

        // Back-pressure: hold out_ready low for 10 cycles in DONE.
        fill(X3, ~X3, 7'd38, 7'd38);
        run_vec("backpressure", X3, E_ALT, 10);

        // Mid-run reset at address 20.
        fill(ONES, ONES, 7'd75, 7'd75);
        in_data  = ONES;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        while (w_addr !== AW'(20) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midreset_reached_addr20", 64'(w_addr), 64'd20);
        @(negedge clk);
        @(negedge clk);
        chk("midreset_partial_nonzero", 64'(out_data != '0), 64'd1);
        rst = 1'b1;
        #1;
        chk("midreset_clear", 64'({out_valid, w_rd_en, busy}), 64'd0);
        chk("midreset_out_data", 64'(out_data), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        fill(X3, ~X3, 7'd38, 7'd38);
        run_vec("after_reset", X3, E_ALT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
